// File: rtl/fp_pkg.sv
// Shared single-precision datapath constants and the mantissa-subtract FSM state type.
// Used by the adder, subtractor/normalizer and rounding stages.
package fp_pkg;

   localparam int unsigned MANT_W  = 24;
   localparam int unsigned EXP_W   = 8;
   localparam int unsigned FRACT_W = 23;

   typedef enum logic [1:0] {
      StIdle,
      StSub,
      StNorm,
      StDone
   } submant_state_t;

endpackage

// File: rtl/submant_norm.sv
// Sequential mantissa subtractor with one-bit-per-cycle left normalization.
// Delivers fraction/exponent/flags to the rounding stage under valid/ready.
module submant_norm
   import fp_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               alessb,
   input  logic [MANT_W-1:0]  manta,
   input  logic [MANT_W-1:0]  mantb,
   input  logic [MANT_W-1:0]  shmant,
   input  logic [EXP_W-1:0]   exp_pre,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FRACT_W-1:0] fract,
   output logic [EXP_W-1:0]   exponent,
   output logic               neg,
   output logic               zero,
   output logic               underflow
);

   submant_state_t     state_q;
   // diff_q holds the larger (unshifted) mantissa until SUB overwrites it with the difference
   logic [MANT_W-1:0]  diff_q;
   logic [MANT_W-1:0]  sh_q;
   logic [EXP_W-1:0]   exp_q;
   logic               out_valid_q;
   logic [FRACT_W-1:0] fract_q;
   logic [EXP_W-1:0]   exponent_q;
   logic               neg_q;
   logic               zero_q;
   logic               underflow_q;

   logic               sh_gt;
   logic [MANT_W-1:0]  sub_res;

   always_comb begin
      sh_gt   = sh_q > diff_q;
      sub_res = sh_gt ? (sh_q - diff_q) : (diff_q - sh_q);
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = out_valid_q;
   assign fract     = fract_q;
   assign exponent  = exponent_q;
   assign neg       = neg_q;
   assign zero      = zero_q;
   assign underflow = underflow_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         diff_q      <= '0;
         sh_q        <= '0;
         exp_q       <= '0;
         out_valid_q <= 1'b0;
         fract_q     <= '0;
         exponent_q  <= '0;
         neg_q       <= 1'b0;
         zero_q      <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  diff_q  <= alessb ? mantb : manta;
                  sh_q    <= shmant;
                  exp_q   <= exp_pre;
                  state_q <= StSub;
               end
            end
            StSub: begin
               diff_q  <= sub_res;
               neg_q   <= sh_gt;
               state_q <= StNorm;
            end
            StNorm: begin
               if (diff_q == '0) begin
                  zero_q      <= 1'b1;
                  fract_q     <= '0;
                  exponent_q  <= '0;
                  underflow_q <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else if (diff_q[MANT_W-1]) begin
                  zero_q      <= 1'b0;
                  fract_q     <= diff_q[FRACT_W-1:0];
                  exponent_q  <= exp_q;
                  underflow_q <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else if (exp_q <= EXP_W'(1)) begin
                  // No exponent headroom left: emit as subnormal without further shifting
                  zero_q      <= 1'b0;
                  fract_q     <= diff_q[FRACT_W-1:0];
                  exponent_q  <= '0;
                  underflow_q <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  diff_q <= {diff_q[MANT_W-2:0], 1'b0};
                  exp_q  <= exp_q - EXP_W'(1);
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_submant_norm.sv
// Scoreboard bench for submant_norm: driver queues expected results, monitor checks them
// (including out_valid rise cycle) whenever the DUT hands a result over.
module tb_submant_norm;
   import fp_pkg::*;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         alessb = 1'b0;
   logic [23:0]  manta = '0;
   logic [23:0]  mantb = '0;
   logic [23:0]  shmant = '0;
   logic [7:0]   exp_pre = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [22:0]  fract;
   logic [7:0]   exponent;
   logic         neg;
   logic         zero;
   logic         underflow;

   typedef struct {
      logic [22:0] fract;
      logic [7:0]  exponent;
      logic        neg;
      logic        zero;
      logic        uf;
      int          rise;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   bit   mon_prev = 1'b0;

   submant_norm dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alessb    (alessb),
      .manta     (manta),
      .mantb     (mantb),
      .shmant    (shmant),
      .exp_pre   (exp_pre),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fract     (fract),
      .exponent  (exponent),
      .neg       (neg),
      .zero      (zero),
      .underflow (underflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Called at posedge+#1 with the DUT expected idle; accept happens on the next edge.
   task automatic send(input logic ab, input logic [23:0] ma, input logic [23:0] mb,
                       input logic [23:0] sh, input logic [7:0] ep, input logic [22:0] ef,
                       input logic [7:0] ee, input logic en, input logic ez, input logic eu,
                       input int lat, input bit push);
      exp_t e;
      alessb   = ab;
      manta    = ma;
      mantb    = mb;
      shmant   = sh;
      exp_pre  = ep;
      in_valid = 1'b1;
      chk("accept_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      manta    = 24'($urandom);
      mantb    = 24'($urandom);
      shmant   = 24'($urandom);
      exp_pre  = 8'($urandom);
      alessb   = 1'($urandom);
      if (push) begin
         e.fract    = ef;
         e.exponent = ee;
         e.neg      = en;
         e.zero     = ez;
         e.uf       = eu;
         e.rise     = cyc + 2 + lat;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_timeout", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: checks rise cycle of out_valid and result fields at each handshake
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_prev = 1'b0;
         end else begin
            if (out_valid && !mon_prev) begin
               if (sb.size() == 0) chk("unexpected_out_valid", out_valid, 0);
               else chk("latency_cycle", cyc, sb[0].rise);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
               e = sb.pop_front();
               chk("fract", fract, e.fract);
               chk("exponent", exponent, e.exponent);
               chk("neg", neg, e.neg);
               chk("zero", zero, e.zero);
               chk("underflow", underflow, e.uf);
            end
            mon_prev = out_valid;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_fract", fract, 0);
      chk("rst_exponent", exponent, 0);
      chk("rst_flags", {neg, zero, underflow}, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // basic one-shift normalize
      send(0, 24'h800000, 24'h000000, 24'h400000, 8'h80, 23'h0, 8'h7F, 0, 0, 0, 1, 1);
      drain();
      // exact zero
      send(0, 24'hC00000, 24'h000000, 24'hC00000, 8'h40, 23'h0, 8'h00, 0, 1, 0, 0, 1);
      drain();
      // alessb selects mantb, already normalized
      send(1, 24'h123456, 24'hFFFFFF, 24'h000001, 8'h10, 23'h7FFFFE, 8'h10, 0, 0, 0, 0, 1);
      drain();
      // shmant larger: negative result
      send(1, 24'hABCDEF, 24'h400000, 24'h800000, 8'h10, 23'h0, 8'h0F, 1, 0, 0, 1, 1);
      drain();
      // two shifts then subnormal stop
      send(0, 24'h800000, 24'h5A5A5A, 24'h7FFFFF, 8'h03, 23'h000004, 8'h00, 0, 0, 1, 2, 1);
      drain();
      // exp_pre==0: subnormal without any shift
      send(0, 24'h800000, 24'h000000, 24'h000001, 8'h00, 23'h7FFFFF, 8'h00, 0, 0, 1, 0, 1);
      drain();

      // backpressure: stall 5 cycles with junk on in_valid
      out_ready = 1'b0;
      send(0, 24'h800000, 24'h000000, 24'h400000, 8'h80, 23'h0, 8'h7F, 0, 0, 0, 1, 1);
      t = 0;
      while (!out_valid && t < 40) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("bp_out_valid_seen", out_valid, 1);
      in_valid = 1'b1;
      manta    = 24'h800000;
      shmant   = 24'h000000;
      exp_pre  = 8'h55;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_hold_fract", fract, 0);
         chk("bp_hold_exponent", exponent, 8'h7F);
         chk("bp_hold_neg", neg, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_ready", in_ready, 1);
      chk("bp_popped", sb.size(), 0);
      // 20-shift op right after release
      send(1, 24'hFFFFFF, 24'h000010, 24'h000008, 8'h80, 23'h0, 8'h6C, 0, 0, 0, 20, 1);
      drain();

      // leave nonzero neg/underflow/fract so reset clearing is visible
      send(0, 24'h000001, 24'h000000, 24'h000003, 8'h01, 23'h000002, 8'h00, 1, 0, 1, 0, 1);
      drain();

      // reset in the middle of a 20-shift normalize
      send(0, 24'h800000, 24'h000000, 24'h7FFFF8, 8'h80, 23'h0, 8'h00, 0, 0, 0, 20, 0);
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_fract", fract, 0);
      chk("mid_rst_exponent", exponent, 0);
      chk("mid_rst_flags", {neg, zero, underflow}, 0);
      @(posedge clk);
      #1;
      chk("rst_held_in_ready", in_ready, 1);
      reset = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("no_ghost_result", out_valid, 0);
      send(0, 24'h800000, 24'h000000, 24'h7FFFF8, 8'h80, 23'h0, 8'h6C, 0, 0, 0, 20, 1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
